// File: rtl/serial_sym_pkg.sv
// Shared widths, encodings and symbol-length helper for serial_sym_arbiter.
// Build option SERIAL_SYM_PARITY_EN appends one even-parity bit to every symbol.
package serial_sym_pkg;

  localparam int ASCII_W    = 7;
  localparam int B64_W      = 6;
  localparam int FRAME_SYMS = 12;

`ifdef SERIAL_SYM_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam logic MODE_ASCII = 1'b0;
  localparam logic MODE_B64   = 1'b1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Shift register holds the widest symbol plus a slot for the parity bit.
  localparam int SR_W  = ASCII_W + 1;
  localparam int CNT_W = 3;

  function automatic logic [3:0] sym_bits(input logic mode, input bit parity);
    int n;
    n = (mode == MODE_B64) ? B64_W : ASCII_W;
    if (parity) n = n + 1;
    return 4'(n);
  endfunction

endpackage

// File: rtl/serial_sym_shifter.sv
// Parallel-load MSB-first shift register with bit down-counter; last flags counter zero.
// Parity bit (SERIAL_SYM_PARITY_EN) is packed directly behind the data bits at load time.
module sym_shifter
  import serial_sym_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [ASCII_W-1:0] sym,
  input  logic               mode,
  output logic               ser_bit,
  output logic               last
);

  logic [SR_W-1:0]  sreg;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  load_val;

  always_comb begin
    load_val = '0;
`ifdef SERIAL_SYM_PARITY_EN
    if (mode == MODE_ASCII) load_val = {sym, ^sym};
    else                    load_val = {sym[B64_W-1:0], ^sym[B64_W-1:0], 1'b0};
`else
    if (mode == MODE_ASCII) load_val = {sym, 1'b0};
    else                    load_val = {sym[B64_W-1:0], 2'b00};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_val;
      cnt  <= CNT_W'(sym_bits(mode, PARITY_EN) - 4'd1);
    end else if (shift) begin
      sreg <= {sreg[SR_W-2:0], 1'b0};
      cnt  <= cnt - CNT_W'(1);
    end
  end

  assign ser_bit = sreg[SR_W-1];
  assign last    = (cnt == '0);

endmodule

// File: rtl/serial_sym_arbiter.sv
// Two-requester symbol arbiter with frame ownership feeding one MSB-first serial line.
// SERIAL_SYM_PARITY_EN (see serial_sym_pkg) adds a parity cycle per symbol.
module serial_sym_arbiter #(
  parameter int FRAME_SYMS = serial_sym_pkg::FRAME_SYMS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [6:0] sym0,
  input  logic       mode0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [6:0] sym1,
  input  logic       mode1,
  output logic       gnt1,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       sym_last,
  output logic       owner,
  output logic       busy
);
  import serial_sym_pkg::*;

  localparam int FC_W = $clog2(FRAME_SYMS + 1);

  state_t          state;
  logic            rr_ptr;
  logic [FC_W-1:0] fcnt;
  logic            sh_bit, sh_last;
  logic            own_req, oth_req;
  logic            do_grant, gsel, frame_end, fcnt_inc;
  logic [6:0]      gsym;
  logic            gmode;

  // Rearbitration happens on the last bit cycle so the next symbol follows with no bubble.
  always_comb begin
    do_grant  = 1'b0;
    gsel      = owner;
    frame_end = 1'b0;
    fcnt_inc  = 1'b0;
    own_req   = owner ? req1 : req0;
    oth_req   = owner ? req0 : req1;
    if (state == IDLE) begin
      if (req0 || req1) begin
        do_grant = 1'b1;
        gsel     = (req0 && req1) ? rr_ptr : req1;
      end
    end else if (sh_last) begin
      if (own_req && (fcnt < FC_W'(FRAME_SYMS))) begin
        do_grant = 1'b1;
        gsel     = owner;
        fcnt_inc = 1'b1;
      end else begin
        frame_end = 1'b1;
        if (oth_req) begin
          do_grant = 1'b1;
          gsel     = ~owner;
        end else if (own_req) begin
          do_grant = 1'b1;
          gsel     = owner;
        end
      end
    end
  end

  assign gnt0  = do_grant & ~gsel;
  assign gnt1  = do_grant & gsel;
  assign gsym  = gsel ? sym1 : sym0;
  assign gmode = gsel ? mode1 : mode0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
      fcnt   <= '0;
    end else begin
      if (frame_end) rr_ptr <= ~owner;
      if (do_grant) begin
        state <= SHIFT;
        owner <= gsel;
        fcnt  <= fcnt_inc ? fcnt + FC_W'(1) : FC_W'(1);
      end else if ((state == SHIFT) && sh_last) begin
        state <= IDLE;
      end
    end
  end

  sym_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (do_grant),
    .shift   (state == SHIFT),
    .sym     (gsym),
    .mode    (gmode),
    .ser_bit (sh_bit),
    .last    (sh_last)
  );

  assign ser_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign ser_out   = ser_valid & sh_bit;
  assign sym_last  = ser_valid & sh_last;

endmodule

// File: tb/tb_serial_sym_arbiter.sv
// Directed bench for serial_sym_arbiter: streams, frame ownership, base64 width and reset.
`timescale 1ns/1ps
module tb_serial_sym_arbiter;

`ifdef SERIAL_SYM_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WA = 7 + PAR;
  localparam int WB = 6 + PAR;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, mode0 = 1'b0, req1 = 1'b0, mode1 = 1'b0;
  logic [6:0] sym0 = '0, sym1 = '0;
  logic       gnt0, gnt1, ser_out, ser_valid, sym_last, owner, busy;
  int         tests = 0;
  int         fails = 0;

  logic [6:0] msg [12] = '{7'h48, 7'h65, 7'h6c, 7'h6c, 7'h6f, 7'h20,
                           7'h57, 7'h6f, 7'h72, 7'h6c, 7'h64, 7'h21};

  always #5 clk = ~clk;

  serial_sym_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .sym0(sym0), .mode0(mode0), .gnt0(gnt0),
    .req1(req1), .sym1(sym1), .mode1(mode1), .gnt1(gnt1),
    .ser_out(ser_out), .ser_valid(ser_valid), .sym_last(sym_last),
    .owner(owner), .busy(busy)
  );

  // Expected serial bit k of a symbol; the bit after the data bits is even parity.
  function automatic logic exp_bit(input logic [6:0] s, input logic m, input int k);
    logic [6:0] v;
    v = s;
    if (m) return (k < 6) ? v[5-k] : ^v[5:0];
    return (k < 7) ? v[6-k] : ^v;
  endfunction

  task automatic do_reset;
    req0 = 1'b0; req1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, ser_out, ser_valid, sym_last, owner, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {gnt0, gnt1, ser_out, ser_valid, sym_last, owner, busy});
    end
    do_reset;
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, ser_valid, busy} !== 4'b0) begin
      fails++;
      $display("FAIL idle_no_req: got %b want 0000", {gnt0, gnt1, ser_valid, busy});
    end
  endtask

  task automatic test_hello;
    int idx = 0;
    int chars = 0;
    logic [6:0] acc = '0;
    logic g0;
    logic [4:0] e, o;
    do_reset;
    req0 = 1'b1; sym0 = msg[0];
    for (int c = 0; c <= 12*WA + 1; c++) begin
      @(negedge clk);
      e = '0;
      e[4] = (c % WA == 0) && (c < 12*WA);
      if (c >= 1 && c <= 12*WA) begin
        e[3] = 1'b1;
        e[2] = ((c-1) % WA == WA-1);
        e[1] = exp_bit(msg[(c-1)/WA], 1'b0, (c-1) % WA);
        e[0] = 1'b1;
      end
      o = {gnt0, ser_valid, sym_last, ser_out, busy};
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL hello_cycle%0d: got %b want %b", c, o, e);
      end
      if (ser_valid && (PAR == 0 || !sym_last)) acc = {acc[5:0], ser_out};
      if (sym_last && chars < 12) begin
        tests++;
        if (acc !== msg[chars]) begin
          fails++;
          $display("FAIL hello_char%0d: got %h want %h", chars, acc, msg[chars]);
        end
        chars++;
      end
      g0 = gnt0;
      @(posedge clk); #1;
      if (g0) idx++;
      req0 = (idx < 12);
      sym0 = (idx < 12) ? msg[idx] : 7'h00;
    end
    tests++;
    if (chars != 12) begin
      fails++;
      $display("FAIL hello_char_count: got %0d want 12", chars);
    end
  endtask

  task automatic test_frame_switch;
    int idx0 = 0, idx1 = 0;
    logic g0, g1;
    logic [3:0] e, o;
    do_reset;
    req0 = 1'b1; sym0 = msg[0];
    req1 = 1'b1; sym1 = 7'h5a;
    for (int c = 0; c <= 14*WA + 1; c++) begin
      @(negedge clk);
      e = '0;
      if (c % WA == 0 && c <= 13*WA) begin
        e[3] = (c / WA != 12);
        e[2] = (c / WA == 12);
      end
      if (c >= 1 && c <= 14*WA) begin
        e[1] = 1'b1;
        e[0] = ((c-1) / WA == 12);
      end
      o = {gnt0, gnt1, ser_valid, ser_valid & owner};
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL frame_switch_cycle%0d: got %b want %b", c, o, e);
      end
      g0 = gnt0; g1 = gnt1;
      @(posedge clk); #1;
      if (g0) idx0++;
      if (g1) idx1++;
      req0 = (idx0 < 13);
      sym0 = msg[idx0 % 12];
      req1 = (idx1 < 1);
    end
  endtask

  task automatic test_frame_full;
    int idx0 = 0;
    logic g0;
    logic [3:0] e, o;
    do_reset;
    req0 = 1'b1; sym0 = msg[0];
    for (int c = 0; c <= 14*WA + 1; c++) begin
      @(negedge clk);
      e = {(c % WA == 0) && (c < 14*WA), 1'b0, (c >= 1 && c <= 14*WA), 1'b0};
      o = {gnt0, gnt1, ser_valid, ser_valid & owner};
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL frame_full_cycle%0d: got %b want %b", c, o, e);
      end
      g0 = gnt0;
      @(posedge clk); #1;
      if (g0) idx0++;
      req0 = (idx0 < 14);
      sym0 = msg[idx0 % 12];
    end
    // Frame ended with owner 0, so a tie from IDLE now goes to requester 1.
    req0 = 1'b1; sym0 = msg[1];
    req1 = 1'b1; sym1 = 7'h5a;
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1} !== 2'b01) begin
      fails++;
      $display("FAIL rr_tie_after_frame: got %b want 01", {gnt0, gnt1});
    end
    @(posedge clk); #1;
    req1 = 1'b0;
    repeat (WA-1) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, owner, sym_last} !== 4'b1011) begin
      fails++;
      $display("FAIL switch_to_req0: got %b want 1011", {gnt0, gnt1, owner, sym_last});
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (WA+2) @(posedge clk);
    #1;
  endtask

  task automatic test_b64;
    int idx1 = 0;
    logic g1;
    logic [3:0] e, o;
    do_reset;
    req1 = 1'b1; mode1 = 1'b1; sym1 = 7'b0100001;
    for (int c = 0; c <= WB + WA + 1; c++) begin
      @(negedge clk);
      e = '0;
      e[3] = (c == 0) || (c == WB);
      if (c >= 1 && c <= WB) begin
        e[2] = 1'b1;
        e[1] = exp_bit(7'b0100001, 1'b1, c-1);
        e[0] = (c == WB);
      end else if (c > WB && c <= WB + WA) begin
        e[2] = 1'b1;
        e[1] = exp_bit(7'h41, 1'b0, c-1-WB);
        e[0] = (c == WB + WA);
      end
      o = {gnt1, ser_valid, ser_out, sym_last};
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL b64_cycle%0d: got %b want %b", c, o, e);
      end
      g1 = gnt1;
      @(posedge clk); #1;
      if (g1) idx1++;
      if (idx1 == 1) begin mode1 = 1'b0; sym1 = 7'h41; end
      req1 = (idx1 < 2);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req0 = 1'b1; sym0 = 7'h55;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (WA) @(posedge clk);
    #1;
    req0 = 1'b1; sym0 = 7'h33;
    @(negedge clk);
    tests++;
    if (gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL mid_second_grant: got %b want 1", gnt0);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    tests++;
    if ({ser_valid, ser_out} !== 2'b11) begin
      fails++;
      $display("FAIL mid_third_bit: got %b want 11", {ser_valid, ser_out});
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({gnt0, gnt1, ser_out, ser_valid, sym_last, owner, busy} !== 7'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b want 0000000",
               {gnt0, gnt1, ser_out, ser_valid, sym_last, owner, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b1; sym0 = msg[0];
    req1 = 1'b1; sym1 = msg[1];
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1} !== 2'b10) begin
      fails++;
      $display("FAIL rr_after_reset: got %b want 10", {gnt0, gnt1});
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (WA+2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_hello;
    test_frame_switch;
    test_frame_full;
    test_b64;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
